// File: rtl/simple_mem_arbiter_if.sv
// simple_mem_arbiter_if: the two requester ports and the shared data-memory port.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the requesters plus the memory.
`timescale 1ns/1ps
interface simple_mem_arbiter_if #(
    parameter int width    = 32,
    parameter int addrsize = 8
);
    // master 0: processor load/store path
    logic                m0_req;
    logic                m0_we;
    logic [addrsize-1:0] m0_addr;
    logic [width-1:0]    m0_wdata;
    logic                m0_gnt;
    logic                m0_rvalid;
    logic [width-1:0]    m0_rdata;
    // master 1: host loader / debug port
    logic                m1_req;
    logic                m1_we;
    logic [addrsize-1:0] m1_addr;
    logic [width-1:0]    m1_wdata;
    logic                m1_gnt;
    logic                m1_rvalid;
    logic [width-1:0]    m1_rdata;
    // shared data-memory port
    logic                mem_en;
    logic                mem_we;
    logic [addrsize-1:0] mem_addr;
    logic [width-1:0]    mem_wdata;
    logic [width-1:0]    mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/simple_mem_arbiter.sv
// simple_mem_arbiter: round-robin sharing of the single data-memory port between
// the processor load/store path (master 0) and the host loader (master 1).
// Only one transfer is in flight at a time. Read data comes back RD_LAT cycles
// after the issue cycle. All outputs are registered.
`timescale 1ns/1ps
module simple_mem_arbiter #(
    parameter int width    = 32,
    parameter int addrsize = 8,
    parameter int RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                nrst,
    simple_mem_arbiter_if.slave bus
);

    if ((RD_LAT < 1) || (RD_LAT > 7)) begin : g_bad_rd_lat
        $error("simple_mem_arbiter: RD_LAT=%0d is outside the legal range 1..7", RD_LAT);
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // WAIT lasts RD_LAT-1 cycles. The counter is loaded with RD_LAT-1, and the
    // FSM leaves WAIT on the cycle in which the decrement reaches zero.
    localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

    state_t              r_state;
    logic [2:0]          r_cnt;
    logic                r_rr_last;
    logic                r_owner;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [addrsize-1:0] r_mem_addr;
    logic [width-1:0]    r_mem_wdata;
    logic                r_m0_gnt;
    logic                r_m1_gnt;
    logic                r_m0_rvalid;
    logic                r_m1_rvalid;
    logic [width-1:0]    r_m0_rdata;
    logic [width-1:0]    r_m1_rdata;

    state_t              w_state_nxt;
    logic [2:0]          w_cnt_nxt;
    logic                w_rr_last_nxt;
    logic                w_owner_nxt;
    logic                w_mem_en_nxt;
    logic                w_mem_we_nxt;
    logic [addrsize-1:0] w_mem_addr_nxt;
    logic [width-1:0]    w_mem_wdata_nxt;
    logic                w_m0_gnt_nxt;
    logic                w_m1_gnt_nxt;
    logic                w_m0_rvalid_nxt;
    logic                w_m1_rvalid_nxt;
    logic [width-1:0]    w_m0_rdata_nxt;
    logic [width-1:0]    w_m1_rdata_nxt;
    logic                w_any_req;
    logic                w_win;

    // Master 1 wins when it is the only requester, or when both request and master 0 was served last.
    assign w_any_req = bus.m0_req | bus.m1_req;
    assign w_win     = bus.m1_req & (~bus.m0_req | ~r_rr_last);

    // Next-state and next-output decode. Strobes default low, and held data defaults to its current value.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rr_last_nxt   = r_rr_last;
        w_owner_nxt     = r_owner;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_m0_gnt_nxt    = 1'b0;
        w_m1_gnt_nxt    = 1'b0;
        w_m0_rvalid_nxt = 1'b0;
        w_m1_rvalid_nxt = 1'b0;
        w_m0_rdata_nxt  = r_m0_rdata;
        w_m1_rdata_nxt  = r_m1_rdata;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt   = ST_ISSUE;
                    w_owner_nxt   = w_win;
                    w_rr_last_nxt = w_win;
                    w_mem_en_nxt  = 1'b1;
                    if (w_win) begin
                        w_mem_we_nxt    = bus.m1_we;
                        w_mem_addr_nxt  = bus.m1_addr;
                        w_mem_wdata_nxt = bus.m1_wdata;
                        w_m1_gnt_nxt    = 1'b1;
                    end else begin
                        w_mem_we_nxt    = bus.m0_we;
                        w_mem_addr_nxt  = bus.m0_addr;
                        w_mem_wdata_nxt = bus.m0_wdata;
                        w_m0_gnt_nxt    = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // mem_we is still valid here because it is only cleared on leaving ISSUE
                if (r_mem_we) begin
                    w_state_nxt = ST_IDLE;
                end else if (RD_LAT == 1) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                if (r_owner) begin
                    w_m1_rdata_nxt  = bus.mem_rdata;
                    w_m1_rvalid_nxt = 1'b1;
                end else begin
                    w_m0_rdata_nxt  = bus.mem_rdata;
                    w_m0_rvalid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // State and registered outputs. Reset clears them asynchronously and drops any read in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_rr_last   <= 1'b1;
            r_owner     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {addrsize{1'b0}};
            r_mem_wdata <= {width{1'b0}};
            r_m0_gnt    <= 1'b0;
            r_m1_gnt    <= 1'b0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= {width{1'b0}};
            r_m1_rdata  <= {width{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rr_last   <= w_rr_last_nxt;
            r_owner     <= w_owner_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_m0_gnt    <= w_m0_gnt_nxt;
            r_m1_gnt    <= w_m1_gnt_nxt;
            r_m0_rvalid <= w_m0_rvalid_nxt;
            r_m1_rvalid <= w_m1_rvalid_nxt;
            r_m0_rdata  <= w_m0_rdata_nxt;
            r_m1_rdata  <= w_m1_rdata_nxt;
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.m0_gnt    = r_m0_gnt;
    assign bus.m1_gnt    = r_m1_gnt;
    assign bus.m0_rvalid = r_m0_rvalid;
    assign bus.m1_rvalid = r_m1_rvalid;
    assign bus.m0_rdata  = r_m0_rdata;
    assign bus.m1_rdata  = r_m1_rdata;

endmodule
